// File: rtl/control_unit_pipelined.sv
// control_unit_pipelined: RV32I(M) decode for the ID stage plus the ID/EX
// control register. Multi-cycle M-extension ops are sequenced by a small
// latency FSM that raises STALL_OUT toward the hazard unit.
//
// Optional feature macro: CTRL_M_EXT_EN
//   defined   - MUL*/DIV*/REM* are decoded and the latency FSM/counter exist.
//   undefined - OP with FUNCT7 = 0000001 is illegal, ALUOP[0] is held at 0,
//               no FSM or counter is built and STALL_OUT is tied low.
//
// Handshake: there is no valid/ready pair here. INSTR_VALID qualifies the ID
// instruction, EX_VALID marks a live EX slot, STALL_IN/STALL_OUT freeze the
// ID/EX register and FLUSH replaces it with a bubble (FLUSH has priority).
module control_unit_pipelined #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 34,
   parameter int CNT_W      = 6
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       INSTR_VALID,
   input  logic [6:0] OPCODE,
   input  logic [2:0] FUNCT3,
   input  logic [6:0] FUNCT7,
   input  logic       STALL_IN,
   input  logic       FLUSH,
   output logic [2:0] IMM_SEL,
   output logic       STALL_OUT,
   output logic       EX_VALID,
   output logic       OP1SEL,
   output logic       OP2SEL,
   output logic       MEM_WRITE,
   output logic       MEM_READ,
   output logic       REG_WRITE_EN,
   output logic [1:0] WB_SEL,
   output logic [4:0] ALUOP,
   output logic [2:0] BRANCH_JUMP,
   output logic [2:0] LOAD_SEL,
   output logic       ILLEGAL
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] F7_MEXT    = 7'b0000001;
   localparam logic [2:0] BJ_NONE    = 3'b010;
   localparam logic [2:0] BJ_JUMP    = 3'b011;

`ifdef CTRL_M_EXT_EN
   localparam logic M_EN = 1'b1;
`else
   localparam logic M_EN = 1'b0;
`endif

   // FUNCT7[0] only reaches ALUOP when the M extension is built in.
   logic f7_lsb;
   assign f7_lsb = FUNCT7[0] & M_EN;

   logic       d_op1, d_op2, d_mw, d_mr, d_rw, d_ill;
   logic [1:0] d_wb;
   logic [4:0] d_alu;
   logic [2:0] d_bj;

   // ID decode: immediate select and the control word for the EX slot.
   always_comb begin
      IMM_SEL = 3'b000;
      d_op1   = 1'b0;
      d_op2   = 1'b0;
      d_mw    = 1'b0;
      d_mr    = 1'b0;
      d_rw    = 1'b0;
      d_wb    = 2'b00;
      d_alu   = 5'b00000;
      d_bj    = BJ_NONE;
      d_ill   = 1'b0;
      case (OPCODE)
         OPC_LUI: begin
            IMM_SEL = 3'b000;
            d_rw    = 1'b1;
            d_wb    = 2'b10;
         end
         OPC_AUIPC: begin
            IMM_SEL = 3'b000;
            d_op1   = 1'b1;
            d_op2   = 1'b1;
            d_rw    = 1'b1;
         end
         OPC_JAL: begin
            IMM_SEL = 3'b001;
            d_op1   = 1'b1;
            d_op2   = 1'b1;
            d_rw    = 1'b1;
            d_wb    = 2'b11;
            d_bj    = BJ_JUMP;
         end
         OPC_JALR: begin
            IMM_SEL = 3'b100;
            d_op2   = 1'b1;
            d_rw    = 1'b1;
            d_wb    = 2'b11;
            d_bj    = BJ_JUMP;
         end
         OPC_BRANCH: begin
            IMM_SEL = 3'b011;
            d_op1   = 1'b1;
            d_op2   = 1'b1;
            d_bj    = FUNCT3;
         end
         OPC_LOAD: begin
            IMM_SEL = 3'b100;
            d_op2   = 1'b1;
            d_mr    = 1'b1;
            d_rw    = 1'b1;
            d_wb    = 2'b01;
         end
         OPC_STORE: begin
            IMM_SEL = 3'b010;
            d_op2   = 1'b1;
            d_mw    = 1'b1;
         end
         OPC_OPIMM: begin
            d_op2 = 1'b1;
            d_rw  = 1'b1;
            if (FUNCT3[1:0] == 2'b01) begin
               // Shifts carry the arithmetic/logical bit in FUNCT7.
               IMM_SEL = 3'b101;
               d_alu   = {FUNCT3, FUNCT7[5], f7_lsb};
            end else begin
               IMM_SEL = (FUNCT3 == 3'b011) ? 3'b111 : 3'b100;
               d_alu   = {FUNCT3, 2'b00};
            end
         end
         OPC_OP: begin
            if (FUNCT7 == F7_MEXT && !M_EN) begin
               d_ill = 1'b1;
            end else begin
               d_rw  = 1'b1;
               d_alu = {FUNCT3, FUNCT7[5], f7_lsb};
            end
         end
         default: d_ill = 1'b1;
      endcase
   end

`ifdef CTRL_M_EXT_EN
   typedef enum logic {IDLE = 1'b0, MD_BUSY = 1'b1} state_t;

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             is_md;
   logic             md_multi;

   assign is_md     = (OPCODE == OPC_OP) && (FUNCT7 == F7_MEXT);
   assign md_multi  = FUNCT3[2] ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1);
   assign STALL_OUT = (state == MD_BUSY) && (cnt != '0);

   // Latency FSM: arm on an M-op entering EX, count down, drop the stall at 0.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (FLUSH) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (STALL_OUT) begin
         // Counts regardless of STALL_IN: the divider keeps working.
         cnt <= cnt - 1'b1;
      end else if (STALL_IN) begin
         state <= IDLE;
      end else if (INSTR_VALID && is_md && md_multi) begin
         state <= MD_BUSY;
         cnt   <= FUNCT3[2] ? DIV_LOAD : MUL_LOAD;
      end else begin
         state <= IDLE;
         cnt   <= '0;
      end
   end
`else
   assign STALL_OUT = 1'b0;
`endif

   // ID/EX control register: flush > stall > load (bubble when ID is empty).
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET || FLUSH) begin
         EX_VALID     <= 1'b0;
         OP1SEL       <= 1'b0;
         OP2SEL       <= 1'b0;
         MEM_WRITE    <= 1'b0;
         MEM_READ     <= 1'b0;
         REG_WRITE_EN <= 1'b0;
         WB_SEL       <= 2'b00;
         ALUOP        <= 5'b00000;
         BRANCH_JUMP  <= BJ_NONE;
         LOAD_SEL     <= 3'b000;
         ILLEGAL      <= 1'b0;
      end else if (!(STALL_OUT || STALL_IN)) begin
         if (INSTR_VALID) begin
            EX_VALID     <= 1'b1;
            OP1SEL       <= d_op1;
            OP2SEL       <= d_op2;
            MEM_WRITE    <= d_mw;
            MEM_READ     <= d_mr;
            REG_WRITE_EN <= d_rw;
            WB_SEL       <= d_wb;
            ALUOP        <= d_alu;
            BRANCH_JUMP  <= d_bj;
            LOAD_SEL     <= FUNCT3;
            ILLEGAL      <= d_ill;
         end else begin
            EX_VALID     <= 1'b0;
            OP1SEL       <= 1'b0;
            OP2SEL       <= 1'b0;
            MEM_WRITE    <= 1'b0;
            MEM_READ     <= 1'b0;
            REG_WRITE_EN <= 1'b0;
            WB_SEL       <= 2'b00;
            ALUOP        <= 5'b00000;
            BRANCH_JUMP  <= BJ_NONE;
            LOAD_SEL     <= 3'b000;
            ILLEGAL      <= 1'b0;
         end
      end
   end

endmodule

// File: doc/control_unit_pipelined.md
Name: control_unit_pipelined

Overview:
- Successor to the combinational RV32IM decode control unit.
- Decodes OPCODE/FUNCT3/FUNCT7 in ID and holds the decoded controls in an ID/EX control register with stall, flush and bubble handling.
- Sequences multi-cycle M-extension ops with a latency counter FSM and drives a stall back to the hazard unit.
- Sits between the IF/ID register and the EX/MEM datapath.

Parameters:
MUL_CYCLES, 2, EX occupancy in cycles for MUL/MULH/MULHSU/MULHU (>=1)
DIV_CYCLES, 34, EX occupancy in cycles for DIV/DIVU/REM/REMU (>=1)
CNT_W, 6, latency counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
INSTR_VALID  in  1  ID holds a valid instruction
OPCODE  in  7  instr[6:0]
FUNCT3  in  3  instr[14:12]
FUNCT7  in  7  instr[31:25]
STALL_IN  in  1  load-use stall from hazard unit; freeze ID/EX
FLUSH  in  1  branch-taken/trap; kill ID and EX
IMM_SEL  out  3  combinational ID immediate select
STALL_OUT  out  1  M-op busy; freeze PC and IF/ID
EX_VALID  out  1  registered; EX slot holds a live instruction
OP1SEL  out  1  registered; 1 = PC, 0 = rs1
OP2SEL  out  1  registered; 1 = imm, 0 = rs2
MEM_WRITE  out  1  registered; store
MEM_READ  out  1  registered; load
REG_WRITE_EN  out  1  registered; writeback enable
WB_SEL  out  2  registered; 00 ALU, 01 MEM, 10 IMM (LUI), 11 PC+4
ALUOP  out  5  registered; {FUNCT3, FUNCT7[5], FUNCT7[0]} for OP/OP-IMM, else 00000 (ADD)
BRANCH_JUMP  out  3  registered; 010 none, 011 JAL/JALR, FUNCT3 for branches
LOAD_SEL  out  3  registered; FUNCT3
ILLEGAL  out  1  registered; undefined opcode/funct in EX

Behaviour:
- Decode: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- OP1SEL: AUIPC, JAL, BRANCH.
- OP2SEL: all types except LUI and OP.
- REG_WRITE_EN: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
- FUNCT7 bits enter ALUOP only for OP and for OP-IMM shifts (FUNCT3 = x01).
- IMM_SEL (combinational, not gated by INSTR_VALID):
  - U 000, J 001, S 010, B 011
  - I/LOAD/JALR 100, OP-IMM shift 101, OP-IMM FUNCT3 = 011 gives 111
- Any other opcode sets ILLEGAL; all enables are 0 for that instruction.
- ID/EX register update priority per rising edge:
  - FLUSH: load a bubble (all registered outputs 0, BRANCH_JUMP 010), FSM to IDLE, counter 0.
  - Else STALL_OUT or STALL_IN: hold all registered values.
  - Else: load decoded controls; EX_VALID = INSTR_VALID. If INSTR_VALID = 0, load a bubble.
- FLUSH wins over STALL_IN and STALL_OUT when they coincide.
- FSM states IDLE and MD_BUSY:
  - IDLE -> MD_BUSY when an M-op (OP, FUNCT7 = 0000001) loads into EX and its latency N > 1.
  - On that load, the counter = N-1. N = MUL_CYCLES if FUNCT3[2] = 0, else DIV_CYCLES.
  - In MD_BUSY the counter decrements each cycle. STALL_OUT = 1 while state = MD_BUSY and counter != 0.
  - MD_BUSY -> IDLE when counter reaches 0. The EX register advances on the next unstalled edge.
  - A total of N cycles elapse in EX before it advances.
  - N = 1 never enters MD_BUSY.
- STALL_OUT is combinational from state/counter only, with no path from the ID inputs.
- STALL_IN during MD_BUSY does not pause the counter.
- Reset (async, any time including mid-M-op):
  - All registered outputs 0, BRANCH_JUMP 010.
  - State IDLE, counter 0, STALL_OUT 0.
- Counter arithmetic is unsigned CNT_W bits and never wraps (no decrement at 0).

Optional Feature:
- Macro CTRL_M_EXT_EN.
- Defined: M-ops are decoded as above and the FSM/counter are present.
- Undefined:
  - OP with FUNCT7 = 0000001 sets ILLEGAL with enables 0.
  - ALUOP[0] is forced to 0.
  - No FSM or counter is built; STALL_OUT is tied to 0.

Test Plan:
- Reset mid-stream, then release -> all registered outputs 0, BRANCH_JUMP 010, EX_VALID 0, STALL_OUT 0.
- ADDI x1,x0,5 (0x00500093), INSTR_VALID = 1 -> IMM_SEL 100 same cycle. Next edge: OP2SEL 1, REG_WRITE_EN 1, WB_SEL 00, ALUOP 00000, EX_VALID 1.
- BNE (OPCODE 1100011, FUNCT3 001) then JAL -> BRANCH_JUMP 001, OP1SEL 1, REG_WRITE_EN 0; then BRANCH_JUMP 011, WB_SEL 11.
- DIV (FUNCT7 0000001, FUNCT3 100), DIV_CYCLES = 34 -> STALL_OUT high for exactly 33 cycles and ALUOP 10001. A second decoded instruction enters EX on the 34th edge.
- DIV in EX with FLUSH on cycle 10 of busy -> next edge: bubble, STALL_OUT 0, IDLE.
- STALL_IN and FLUSH together with a LW in ID -> bubble loaded, MEM_READ 0. With STALL_IN only, the previous EX values are held.
